weight_fetch_ctrl: RTL and testbench
====================================

// Module: weight_fetch_ctrl
// PURPOSE
//  Responder side of the wfc_* load-weights configuration issued by topcontrol. On a wfc_conf pulse it
//  reads wfc_weight_num weight words from DDR over an AXI-style read channel (AR/R, one burst in flight).
//  It packs DDR beats into X_PE*X_MESH-byte words and writes them into the weight buffer from wb_st_addr upward.
//  It reports wfc_idle back to topcontrol, which holds dependent compute instructions until idle.
// PARAMETERS
//  X_PE          16   PE columns; word bytes = X_PE*X_MESH
//  X_MESH        16   mesh rows
//  ADDR_LEN_WB   6    weight-buffer address width
//  SINGLE_LEN    24   width of count/byte fields
//  DDR_ADDR_LEN  32   DDR byte-address width
//  DDR_DATA_W    512  R-channel data width; BEAT_BYTES=DDR_DATA_W/8; BPW=X_PE*X_MESH*8/DDR_DATA_W (=4)
//  MAX_BURST     16   max beats per AR burst
// PORTS
//  clk              in   1              clock
//  rst_n            in   1              synchronous, active-low reset
//  wfc_conf         in   1              1-cycle config strobe, sampled only when wfc_idle=1
//  wfc_weight_num   in   SINGLE_LEN     words to load (wb address advances by this)
//  wfc_weight_ddr_byte in SINGLE_LEN    total bytes; must equal weight_num*X_PE*X_MESH
//  wfc_ddr_st_addr  in   DDR_ADDR_LEN   DDR start byte address, BEAT_BYTES aligned
//  wfc_wb_st_addr   in   ADDR_LEN_WB    first weight-buffer word address
//  wfc_idle         out  1              1 = ready for new config
//  wfc_err          out  1              sticky error, cleared on next accepted conf
//  m_araddr         out  DDR_ADDR_LEN   burst byte address
//  m_arlen          out  8              beats-1
//  m_arvalid        out  1              AR valid
//  m_arready        in   1              AR ready
//  m_rdata          in   DDR_DATA_W     read data
//  m_rresp          in   2              read response
//  m_rlast          in   1              last beat of burst
//  m_rvalid         in   1              R valid
//  m_rready         out  1              R ready
//  wb_wr_en         out  1              weight-buffer write strobe
//  wb_wr_addr       out  ADDR_LEN_WB    write address
//  wb_wr_data       out  X_PE*X_MESH*8  packed word
// BEHAVIOUR
//  Reset: wfc_idle=1, wfc_err=0, m_arvalid=0, m_araddr=0, m_arlen=0, m_rready=0, wb_wr_en=0,
//   wb_wr_addr=0, wb_wr_data=0, FSM=IDLE. Mid-operation reset aborts; in-flight R beats are not drained.
//  FSM IDLE->ADDR->DATA->(ADDR|DONE)->IDLE.
//  IDLE: wfc_conf=1 latches all fields, rem_beats=num*BPW, clears err; wfc_idle<=0 at that edge.
//   wfc_conf while not idle is ignored. num=0 -> DONE directly, no AR.
//   ddr_byte != num*X_PE*X_MESH -> err<=1; load still driven by num.
//  ADDR: len=min(rem_beats, MAX_BURST, beats left to next 4KB boundary); m_arvalid=1, m_arlen=len-1.
//   Hold araddr/arlen stable until arvalid&arready, then ->DATA, arvalid<=0.
//  DATA: m_rready=1. Each rvalid beat goes to slot beat_idx (0..BPW-1, slot 0 = LSBs of word).
//   The beat with beat_idx=BPW-1 pulses wb_wr_en the next cycle with wb_wr_addr, then wr_addr+1 (mod 2^ADDR_LEN_WB).
//   Beat count reaching len ends the burst; araddr+=len*BEAT_BYTES; rem_beats-=len.
//   rem_beats>0 -> ADDR, else -> DONE.
//   rresp!=0, rlast=0 on final counted beat, or rlast=1 early -> err<=1. Internal counter governs; no stall.
//  Bursts may split a word; beat_idx carries across bursts.
//  DONE: one cycle, waits for the final wb_wr_en; then wfc_idle<=1, ->IDLE.
//  Latency conf->idle low: 1 cycle. Last rvalid beat -> wb_wr_en: 1 cycle. -> idle high: 2 cycles.
// TESTING
//  T1 num=2, byte=512, ddr=0x1000, wb=5, arready/rvalid always 1 -> one AR len=7 @0x1000.
//   Writes to addr 5,6; word0 = beats 3..0 concatenated; idle high 2 cycles after beat 7.
//  T2 num=8, ddr=0x0 -> two ARs, 0x0 arlen=15 and 0x400 arlen=15; 8 writes to wb 0..7.
//  T3 num=1, ddr=0xFC0 -> AR 0xFC0 len=1 then AR 0x1000 len=3; one word written; err=0.
//  T4 wb=62, num=3 -> writes to 62, 63, 0 (wrap); rvalid gaps of 3 cycles produce identical data.
//  T5 rresp=2 on beat 1, then next conf -> err=1 until the new conf is accepted, then 0.
//   conf pulsed during busy -> ignored, single load completes.
//  T6 num=0 -> no AR, idle low exactly 2 cycles. rst_n=0 mid-DATA -> all outputs at reset values next cycle.

Source files
------------

// File: rtl/weight_fetch_ctrl.sv
// weight_fetch_ctrl
//   On a wfc_conf strobe (accepted only while idle) this block loads
//   wfc_weight_num words from DDR into the weight buffer. It issues AR bursts
//   one at a time and collects BPW beats per word, lowest beat in the LSBs.
//   Each completed word is written to the weight buffer at consecutive
//   addresses, starting at wfc_wb_st_addr and wrapping modulo 2^ADDR_LEN_WB.
//   Bursts are limited to MAX_BURST beats and never cross a 4 KB page.
//
// Ports
//   clk, rst_n                 clock, synchronous active-low reset
//   wfc_conf / wfc_*           load request: word count, byte count,
//                              DDR start, weight-buffer start
//   wfc_idle                   1 = ready for a new request
//   wfc_err                    sticky error, cleared when the next request
//                              is accepted
//   m_ar* / m_r*               AXI-style read address / read data channels
//   wb_wr_en/addr/data         weight-buffer write port (one word per pulse)
//
// state | meaning
// IDLE  | waiting for wfc_conf (wfc_idle rises one cycle after entry)
// ADDR  | AR presented, waiting for m_arready
// DATA  | accepting R beats of the current burst
// DONE  | final word write in flight, then back to IDLE
module weight_fetch_ctrl #(
    parameter int X_PE         = 16,
    parameter int X_MESH       = 16,
    parameter int ADDR_LEN_WB  = 6,
    parameter int SINGLE_LEN   = 24,
    parameter int DDR_ADDR_LEN = 32,
    parameter int DDR_DATA_W   = 512,
    parameter int MAX_BURST    = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         wfc_conf,
    input  logic [SINGLE_LEN-1:0]        wfc_weight_num,
    input  logic [SINGLE_LEN-1:0]        wfc_weight_ddr_byte,
    input  logic [DDR_ADDR_LEN-1:0]      wfc_ddr_st_addr,
    input  logic [ADDR_LEN_WB-1:0]       wfc_wb_st_addr,
    output logic                         wfc_idle,
    output logic                         wfc_err,
    output logic [DDR_ADDR_LEN-1:0]      m_araddr,
    output logic [7:0]                   m_arlen,
    output logic                         m_arvalid,
    input  logic                         m_arready,
    input  logic [DDR_DATA_W-1:0]        m_rdata,
    input  logic [1:0]                   m_rresp,
    input  logic                         m_rlast,
    input  logic                         m_rvalid,
    output logic                         m_rready,
    output logic                         wb_wr_en,
    output logic [ADDR_LEN_WB-1:0]       wb_wr_addr,
    output logic [X_PE*X_MESH*8-1:0]     wb_wr_data
);
    localparam int WORD_BYTES = X_PE * X_MESH;
    localparam int WORD_W     = WORD_BYTES * 8;
    localparam int BEAT_BYTES = DDR_DATA_W / 8;
    localparam int BPW        = WORD_W / DDR_DATA_W;
    localparam int BPW_LOG    = $clog2(BPW);
    localparam int BEAT_LOG   = $clog2(BEAT_BYTES);
    localparam int WORD_LOG   = $clog2(WORD_BYTES);
    localparam int REM_W      = SINGLE_LEN + BPW_LOG;
    localparam int LEN_W      = $clog2(MAX_BURST + 1);
    localparam int PAGE_BEATS = 4096 / BEAT_BYTES;
    localparam int PG_W       = 12 - BEAT_LOG;

    typedef enum logic [1:0] {IDLE, ADDR, DATA, DONE} state_t;

    state_t                          state, state_nxt;
    logic [REM_W-1:0]                rem_beats;
    logic [LEN_W-1:0]                burst_len;
    logic [LEN_W-1:0]                beat_cnt;
    logic [BPW_LOG-1:0]              beat_idx;
    logic [ADDR_LEN_WB-1:0]          wr_ptr;
    logic [(BPW-1)*DDR_DATA_W-1:0]   pack;

    logic                            accept;
    logic                            size_bad;
    logic                            last_in_burst;
    logic                            burst_end;
    logic [REM_W-1:0]                rem_init;
    logic [REM_W-1:0]                rem_nxt;
    logic [DDR_ADDR_LEN-1:0]         addr_nxt;
    logic [LEN_W-1:0]                first_len;
    logic [LEN_W-1:0]                next_len;

    // Beats for the next burst: bounded by what is left, the burst cap and
    // the distance to the next 4 KB page (addresses are beat aligned).
    function automatic logic [LEN_W-1:0] calc_len(input logic [PG_W-1:0] page_off,
                                                  input logic [REM_W-1:0] rem);
        logic [REM_W-1:0] to_page;
        logic [REM_W-1:0] len;
        to_page = REM_W'(PAGE_BEATS) - REM_W'(page_off);
        len = rem;
        if (len > REM_W'(MAX_BURST)) len = REM_W'(MAX_BURST);
        if (len > to_page) len = to_page;
        return LEN_W'(len);
    endfunction

    assign accept        = (state == IDLE) && wfc_idle && wfc_conf;
    assign rem_init      = {wfc_weight_num, {BPW_LOG{1'b0}}};
    assign size_bad      = {wfc_weight_num, {WORD_LOG{1'b0}}} !=
                           {{WORD_LOG{1'b0}}, wfc_weight_ddr_byte};
    assign first_len     = calc_len(wfc_ddr_st_addr[11:BEAT_LOG], rem_init);
    assign last_in_burst = (beat_cnt + LEN_W'(1)) == burst_len;
    assign burst_end     = (state == DATA) && m_rvalid && last_in_burst;
    assign addr_nxt      = m_araddr + (DDR_ADDR_LEN'(burst_len) << BEAT_LOG);
    assign rem_nxt       = rem_beats - REM_W'(burst_len);
    assign next_len      = calc_len(addr_nxt[11:BEAT_LOG], rem_nxt);
    assign m_rready      = (state == DATA);

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = (wfc_weight_num == '0) ? DONE : ADDR;
            ADDR:    if (m_arvalid && m_arready) state_nxt = DATA;
            DATA:    if (burst_end) state_nxt = (rem_nxt == '0) ? DONE : ADDR;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wfc_idle   <= 1'b1;
            wfc_err    <= 1'b0;
            m_araddr   <= '0;
            m_arlen    <= '0;
            m_arvalid  <= 1'b0;
            wb_wr_en   <= 1'b0;
            wb_wr_addr <= '0;
            wb_wr_data <= '0;
            rem_beats  <= '0;
            burst_len  <= '0;
            beat_cnt   <= '0;
            beat_idx   <= '0;
            wr_ptr     <= '0;
            pack       <= '0;
        end else begin
            wb_wr_en <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        wfc_idle  <= 1'b0;
                        wfc_err   <= size_bad;
                        m_araddr  <= wfc_ddr_st_addr;
                        rem_beats <= rem_init;
                        wr_ptr    <= wfc_wb_st_addr;
                        beat_idx  <= '0;
                        beat_cnt  <= '0;
                        if (wfc_weight_num != '0) begin
                            burst_len <= first_len;
                            m_arlen   <= 8'(first_len) - 8'd1;
                            m_arvalid <= 1'b1;
                        end
                    end else begin
                        // Raised one cycle after re-entering IDLE so the
                        // last word write has settled before topcontrol
                        // releases dependent instructions.
                        wfc_idle <= 1'b1;
                    end
                end
                ADDR: begin
                    if (m_arready) m_arvalid <= 1'b0;
                end
                DATA: begin
                    if (m_rvalid) begin
                        if ((m_rresp != 2'b00) || (m_rlast != last_in_burst))
                            wfc_err <= 1'b1;
                        beat_idx <= beat_idx + BPW_LOG'(1);
                        if (beat_idx == BPW_LOG'(BPW - 1)) begin
                            wb_wr_en   <= 1'b1;
                            wb_wr_addr <= wr_ptr;
                            wb_wr_data <= {m_rdata, pack};
                            wr_ptr     <= wr_ptr + ADDR_LEN_WB'(1);
                        end else begin
                            for (int i = 0; i < BPW - 1; i++)
                                if (beat_idx == BPW_LOG'(i))
                                    pack[i*DDR_DATA_W +: DDR_DATA_W] <= m_rdata;
                        end
                        // The internal beat count ends the burst; m_rlast
                        // only feeds the error flag.
                        if (last_in_burst) begin
                            beat_cnt  <= '0;
                            m_araddr  <= addr_nxt;
                            rem_beats <= rem_nxt;
                            if (rem_nxt != '0) begin
                                burst_len <= next_len;
                                m_arlen   <= 8'(next_len) - 8'd1;
                                m_arvalid <= 1'b1;
                            end
                        end else begin
                            beat_cnt <= beat_cnt + LEN_W'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_weight_fetch_ctrl.sv
module tb_weight_fetch_ctrl;
    localparam int DW = 512;
    localparam int WW = 2048;
    localparam int AW = 6;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          conf;
    logic [23:0]   weight_num;
    logic [23:0]   ddr_byte;
    logic [31:0]   ddr_st;
    logic [AW-1:0] wb_st;
    logic          wfc_idle;
    logic          wfc_err;
    logic [31:0]   m_araddr;
    logic [7:0]    m_arlen;
    logic          m_arvalid;
    logic          m_arready;
    logic [DW-1:0] m_rdata;
    logic [1:0]    m_rresp;
    logic          m_rlast;
    logic          m_rvalid;
    logic          m_rready;
    logic          wb_wr_en;
    logic [AW-1:0] wb_wr_addr;
    logic [WW-1:0] wb_wr_data;

    weight_fetch_ctrl dut (
        .clk(clk), .rst_n(rst_n), .wfc_conf(conf),
        .wfc_weight_num(weight_num), .wfc_weight_ddr_byte(ddr_byte),
        .wfc_ddr_st_addr(ddr_st), .wfc_wb_st_addr(wb_st),
        .wfc_idle(wfc_idle), .wfc_err(wfc_err),
        .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arvalid(m_arvalid),
        .m_arready(m_arready), .m_rdata(m_rdata), .m_rresp(m_rresp),
        .m_rlast(m_rlast), .m_rvalid(m_rvalid), .m_rready(m_rready),
        .wb_wr_en(wb_wr_en), .wb_wr_addr(wb_wr_addr), .wb_wr_data(wb_wr_data)
    );

    always #5 clk = ~clk;

    typedef struct { int addr; int len; } ar_t;

    int checks = 0;
    int errors = 0;
    ar_t exp_ar[$];
    logic [DW-1:0] beats[$];
    int wr_seen, beat_total, err_beat, gap_mode, wb_base;
    int nedge, wr_due_neg, last_beat_neg, idle_rise_neg, idle_fall_neg;
    int blen, bbeat, gap_cnt;
    bit ar_rand, burst_active, prev_idle;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference burst plan: split num*4 beats into bursts of at most 16
    // beats that never cross a 4096-byte page.
    task automatic plan_bursts(input int ddr, input int num);
        int addr, rem, l, room;
        exp_ar.delete();
        addr = ddr;
        rem  = num * 4;
        while (rem > 0) begin
            room = (4096 - (addr % 4096)) / 64;
            l = rem;
            if (l > 16) l = 16;
            if (l > room) l = room;
            exp_ar.push_back('{addr, l});
            addr += l * 64;
            rem  -= l;
        end
    endtask

    task automatic check_reset_outputs();
        chk("rst_idle", wfc_idle, 1);
        chk("rst_err", wfc_err, 0);
        chk("rst_arvalid", m_arvalid, 0);
        chk("rst_araddr", m_araddr, 0);
        chk("rst_arlen", m_arlen, 0);
        chk("rst_rready", m_rready, 0);
        chk("rst_wr_en", wb_wr_en, 0);
        chk("rst_wr_addr", wb_wr_addr, 0);
        checks++;
        assert (wb_wr_data === '0) else begin
            errors++;
            $error("FAIL rst_wr_data: got low 0x%h expected 0", wb_wr_data[63:0]);
        end
    endtask

    task automatic start_load(input int num, input int bytes, input int ddr, input int wb,
                              input int gmode, input bit arr, input int eb);
        plan_bursts(ddr, num);
        beats.delete();
        wr_seen    = 0;
        beat_total = 0;
        wb_base    = wb;
        gap_mode   = gmode;
        ar_rand    = arr;
        err_beat   = eb;
        @(negedge clk);
        conf       = 1'b1;
        weight_num = 24'(num);
        ddr_byte   = 24'(bytes);
        ddr_st     = 32'(ddr);
        wb_st      = AW'(wb);
        @(negedge clk);
        conf = 1'b0;
        chk("idle_fall", wfc_idle, 0);
        chk("err_accept", wfc_err, (bytes != num * 256) ? 1 : 0);
    endtask

    task automatic run_load(input int num, input int bytes, input int ddr, input int wb,
                            input int gmode, input bit arr, input int eb, input bit busy);
        bit done;
        int exp_err;
        exp_err = ((bytes != num * 256) || (eb >= 0 && eb < num * 4)) ? 1 : 0;
        start_load(num, bytes, ddr, wb, gmode, arr, eb);
        done = 1'b0;
        for (int i = 0; i < 4000 && !done; i++) begin
            @(negedge clk);
            if (busy && i == 3) begin
                conf       = 1'b1;
                weight_num = 24'd9;
                ddr_byte   = 24'd2304;
                ddr_st     = 32'h2000;
                wb_st      = AW'(20);
            end
            if (busy && i == 4) conf = 1'b0;
            if (wfc_idle) done = 1'b1;
        end
        chk("idle_timeout", done, 1);
        @(negedge clk);
        chk("words_written", wr_seen, num);
        chk("ar_left", exp_ar.size(), 0);
        chk("err_end", wfc_err, exp_err);
        if (num > 0) chk("idle_lat", idle_rise_neg - last_beat_neg, 3);
        else         chk("idle_low", idle_rise_neg - idle_fall_neg, 2);
    endtask

    initial begin
        rst_n = 1'b0; conf = 1'b0; weight_num = '0; ddr_byte = '0; ddr_st = '0; wb_st = '0;
        m_arready = 1'b0; m_rdata = '0; m_rresp = '0; m_rlast = 1'b0; m_rvalid = 1'b0;
        wr_seen = 0; beat_total = 0; err_beat = -1; gap_mode = 0; wb_base = 0;
        nedge = 0; wr_due_neg = 0; last_beat_neg = 0; idle_rise_neg = 0; idle_fall_neg = 0;
        blen = 0; bbeat = 0; gap_cnt = 0; ar_rand = 1'b0; burst_active = 1'b0; prev_idle = 1'b1;
        fork
            begin : slave
                logic [WW-1:0] ew;
                logic [DW-1:0] d;
                ar_t e;
                int k;
                forever begin
                    @(negedge clk);
                    nedge++;
                    if (!rst_n) begin
                        m_arready = 1'b0; m_rvalid = 1'b0; m_rlast = 1'b0; m_rresp = 2'b00;
                        burst_active = 1'b0; prev_idle = 1'b1;
                    end else begin
                        if (wfc_idle && !prev_idle) idle_rise_neg = nedge;
                        if (!wfc_idle && prev_idle) idle_fall_neg = nedge;
                        prev_idle = wfc_idle;
                        if (wb_wr_en) begin
                            k  = wr_seen;
                            ew = '0;
                            for (int j = 0; j < 4; j++)
                                if (4 * k + j < beats.size()) ew[j*DW +: DW] = beats[4*k+j];
                            chk("wr_addr", wb_wr_addr, (wb_base + k) % 64);
                            chk("wr_lat", nedge, wr_due_neg);
                            checks++;
                            assert (wb_wr_data === ew) else begin
                                errors++;
                                $error("FAIL wr_data word %0d: got low 0x%h expected low 0x%h",
                                       k, wb_wr_data[63:0], ew[63:0]);
                            end
                            wr_seen++;
                        end
                        m_rvalid = 1'b0; m_rlast = 1'b0; m_rresp = 2'b00;
                        if (burst_active && m_rready) begin
                            if (gap_cnt > 0) gap_cnt--;
                            else begin
                                for (int j = 0; j < DW / 32; j++) d[j*32 +: 32] = $urandom;
                                m_rdata  = d;
                                m_rvalid = 1'b1;
                                m_rresp  = (beat_total == err_beat) ? 2'b10 : 2'b00;
                                m_rlast  = (bbeat == blen - 1);
                                beats.push_back(d);
                                if (beat_total % 4 == 3) wr_due_neg = nedge + 1;
                                last_beat_neg = nedge;
                                beat_total++;
                                bbeat++;
                                if (bbeat == blen) burst_active = 1'b0;
                                gap_cnt = (gap_mode < 0) ? int'($urandom_range(0, 2)) : gap_mode;
                            end
                        end
                        if (!burst_active) begin
                            m_arready = ar_rand ? ($urandom_range(0, 1) == 1) : 1'b1;
                            if (m_arvalid && m_arready) begin
                                checks++;
                                assert (exp_ar.size() > 0) else begin
                                    errors++;
                                    $error("FAIL ar_extra: got AR at 0x%0h expected none", m_araddr);
                                end
                                if (exp_ar.size() > 0) begin
                                    e = exp_ar.pop_front();
                                    chk("ar_addr", m_araddr, e.addr);
                                    chk("ar_len", m_arlen, e.len - 1);
                                end
                                burst_active = 1'b1;
                                blen    = int'(m_arlen) + 1;
                                bbeat   = 0;
                                gap_cnt = 0;
                            end
                        end else begin
                            m_arready = 1'b0;
                        end
                    end
                end
            end
            begin : main
                int n, b, eb;
                bit ok;
                repeat (3) @(negedge clk);
                check_reset_outputs();
                rst_n = 1'b1;
                repeat (2) @(negedge clk);

                // T1: single burst of 8 beats, two words at 5 and 6
                run_load(2, 512, 'h1000, 5, 0, 1'b0, -1, 1'b0);
                // T2: two full 16-beat bursts
                run_load(8, 2048, 'h0, 0, 0, 1'b0, -1, 1'b0);
                // T3: 4 KB page split inside one word
                run_load(1, 256, 'hFC0, 10, 0, 1'b0, -1, 1'b0);
                // T4: address wrap with 3-cycle beat gaps
                run_load(3, 768, 'h2000, 62, 3, 1'b0, -1, 1'b0);
                // conf pulsed while busy must be ignored
                run_load(3, 768, 'h3000, 30, 3, 1'b0, -1, 1'b1);
                // T5: bad rresp on beat 1, error stays until the next accept
                run_load(2, 512, 'h4000, 0, 0, 1'b0, 1, 1'b0);
                repeat (5) @(negedge clk);
                chk("err_sticky", wfc_err, 1);
                run_load(1, 256, 'h4400, 3, 0, 1'b0, -1, 1'b0);
                // byte count mismatch flags error but load follows num
                run_load(2, 300, 'h5000, 40, 0, 1'b0, -1, 1'b0);
                // T6: num=0
                run_load(0, 0, 'h6000, 7, 0, 1'b0, -1, 1'b0);

                // Randomized loads with random arready and beat gaps
                for (int r = 0; r < 8; r++) begin
                    n  = int'($urandom_range(1, 6));
                    b  = ($urandom_range(0, 3) == 0) ? n * 256 + 64 : n * 256;
                    eb = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, n * 4 - 1)) : -1;
                    run_load(n, b, int'($urandom_range(0, 127)) * 64, int'($urandom_range(0, 63)),
                             -1, 1'b1, eb, 1'b0);
                end

                // T6: reset in the middle of a data burst
                start_load(4, 1024, 'h7000, 9, 0, 1'b0, -1);
                ok = 1'b0;
                for (int i = 0; i < 200 && !ok; i++) begin
                    @(negedge clk);
                    if (m_rready) ok = 1'b1;
                end
                chk("rready_timeout", ok, 1);
                repeat (3) @(negedge clk);
                rst_n = 1'b0;
                @(negedge clk);
                check_reset_outputs();
                rst_n = 1'b1;
                repeat (3) @(negedge clk);
                chk("post_rst_arvalid", m_arvalid, 0);
                run_load(2, 512, 'h8000, 12, 0, 1'b0, -1, 1'b0);

                $display("Simulation finished: %0d checks, %0d errors", checks, errors);
                $finish;
            end
        join_any
    end
endmodule
